// File: rtl/bsg_mul_iterative_booth4.sv
// Iterative radix-4 Booth multiplier: folds digits_per_iter_p Booth digits per cycle
// into a carry-save accumulator, then resolves the product with one carry-propagate add.
module bsg_mul_iterative_booth4 #(
  parameter int width_p           = 32,
  parameter int digits_per_iter_p = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  output logic                   ready_o,
  input  logic                   v_i,
  input  logic [width_p-1:0]     opA_i,
  input  logic [width_p-1:0]     opB_i,
  input  logic                   opA_signed_i,
  input  logic                   opB_signed_i,
  input  logic                   kill_i,
  output logic                   v_o,
  output logic [2*width_p-1:0]   result_o,
  input  logic                   yumi_i
);

  localparam int booth_digits_lp = (width_p + 2) / 2;
  localparam int iter_lp         = (booth_digits_lp + digits_per_iter_p - 1) / digits_per_iter_p;
  localparam int acc_w_lp        = 2 * width_p + 2;
  localparam int booth_w_lp      = width_p + 3;
  localparam int step_lp         = 2 * digits_per_iter_p;
  localparam int cnt_w_lp        = (iter_lp > 1) ? $clog2(iter_lp) : 1;
  localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(iter_lp - 1);

  typedef enum logic [1:0] {eIdle, eCal, eCPA, eDone} state_e;

  state_e state_reg, state_next;

  logic [acc_w_lp-1:0]   a_reg;       // +A, pre-shifted to the current iteration's weight
  logic [acc_w_lp-1:0]   na_reg;      // ~A, same alignment as a_reg
  logic [acc_w_lp-1:0]   pos_reg;     // one-hot weight of digit 0 of this iteration
  logic [booth_w_lp-1:0] booth_reg;
  logic [acc_w_lp-1:0]   sum_reg, carry_reg;
  logic [cnt_w_lp-1:0]   cnt_reg;
  logic [2*width_p-1:0]  result_reg;

  logic                  accept_w;
  logic [acc_w_lp-1:0]   a_ext_w;
  logic [booth_w_lp-1:0] booth_load_w;
  logic [booth_w_lp-1:0] booth_shift_w;
  logic                  b_ext_w;

  logic [acc_w_lp-1:0]   pp_w      [digits_per_iter_p];
  logic [acc_w_lp-1:0]   corr_pp_w [digits_per_iter_p];
  logic [acc_w_lp-1:0]   corr_all_w;
  logic [acc_w_lp-1:0]   csa_s, csa_c, csa_t;

  assign accept_w      = ready_o & v_i;
  assign a_ext_w       = {{(width_p + 2){opA_signed_i & opA_i[width_p-1]}}, opA_i};
  assign b_ext_w       = opB_signed_i & opB_i[width_p-1];
  assign booth_load_w  = {{2{b_ext_w}}, opB_i, 1'b0};
  // Arithmetic shift so digits beyond the top read as 000/111, i.e. zero digits.
  assign booth_shift_w = $signed(booth_reg) >>> step_lp;

  // Partial product and negation correction for each digit slot of this iteration.
  for (genvar gi = 0; gi < digits_per_iter_p; gi++) begin : gen_digit
    logic [2:0] trip_w;
    logic       pos1_w, pos2_w, neg1_w, neg2_w;
    assign trip_w = booth_reg[2*gi+2 -: 3];
    assign pos1_w = (trip_w == 3'b001) | (trip_w == 3'b010);
    assign pos2_w = (trip_w == 3'b011);
    assign neg2_w = (trip_w == 3'b100);
    assign neg1_w = (trip_w == 3'b101) | (trip_w == 3'b110);
    // -2A: ~(2A) has a 1 in its LSB, which lands at the digit's own weight.
    assign pp_w[gi] = pos1_w ? (a_reg << (2*gi))
                    : pos2_w ? (a_reg << (2*gi + 1))
                    : neg2_w ? ((na_reg << (2*gi + 1)) | (pos_reg << (2*gi)))
                    : neg1_w ? (na_reg << (2*gi))
                    : '0;
    assign corr_pp_w[gi] = (neg1_w | neg2_w) ? (pos_reg << (2*gi)) : '0;
  end

  // 3:2 compressor chain: fold every partial product, then the correction vector.
  always_comb begin
    corr_all_w = '0;
    for (int j = 0; j < digits_per_iter_p; j++) begin
      corr_all_w = corr_all_w | corr_pp_w[j];
    end
    csa_s = sum_reg;
    csa_c = carry_reg;
    csa_t = '0;
    for (int j = 0; j < digits_per_iter_p; j++) begin
      csa_t = csa_s ^ csa_c ^ pp_w[j];
      csa_c = ((csa_s & csa_c) | (csa_s & pp_w[j]) | (csa_c & pp_w[j])) << 1;
      csa_s = csa_t;
    end
    csa_t = csa_s ^ csa_c ^ corr_all_w;
    csa_c = ((csa_s & csa_c) | (csa_s & corr_all_w) | (csa_c & corr_all_w)) << 1;
    csa_s = csa_t;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg <= eIdle;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ready_o    = 1'b0;
    v_o        = 1'b0;
    case (state_reg)
      eIdle: begin
        ready_o = 1'b1;
        if (v_i) state_next = eCal;
      end
      eCal:    if (cnt_reg == last_cnt_lp) state_next = eCPA;
      eCPA:    state_next = eDone;
      eDone: begin
        v_o = 1'b1;
        if (yumi_i) state_next = eIdle;
      end
      default: state_next = eIdle;
    endcase
    if (kill_i && state_reg != eIdle) state_next = eIdle;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      a_reg      <= '0;
      na_reg     <= '0;
      pos_reg    <= '0;
      booth_reg  <= '0;
      sum_reg    <= '0;
      carry_reg  <= '0;
      cnt_reg    <= '0;
      result_reg <= '0;
    end else begin
      if (accept_w) begin
        a_reg     <= a_ext_w;
        na_reg    <= ~a_ext_w;
        pos_reg   <= acc_w_lp'(1);
        booth_reg <= booth_load_w;
        sum_reg   <= '0;
        carry_reg <= '0;
        cnt_reg   <= '0;
      end else if (state_reg == eCal && !kill_i) begin
        a_reg     <= a_reg << step_lp;
        na_reg    <= na_reg << step_lp;
        pos_reg   <= pos_reg << step_lp;
        booth_reg <= booth_shift_w;
        sum_reg   <= csa_s;
        carry_reg <= csa_c;
        cnt_reg   <= cnt_reg + cnt_w_lp'(1);
      end
      if (state_reg == eCPA && !kill_i) begin
        result_reg <= sum_reg[2*width_p-1:0] + carry_reg[2*width_p-1:0];
      end
    end
  end

  assign result_o = result_reg;

  yumi_legal_a: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_mul_iterative_booth4.sv
// Bench for bsg_mul_iterative_booth4: directed corner cases plus randomized operands
// on three digit-per-iteration configurations, checked against plain integer multiplication.
module tb_bsg_mul_iterative_booth4;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0]     v_r, yumi_r, ready_w, v_o_w;
  logic [W-1:0]   a_r, b_r;
  logic           sa_r, sb_r, kill_r;
  logic [2*W-1:0] res_w [3];

  int checks = 0;
  int errors = 0;

  bsg_mul_iterative_booth4 #(.width_p(W), .digits_per_iter_p(1)) dut_d1 (
    .clk_i(clk), .reset_n_i(rst_n), .ready_o(ready_w[0]), .v_i(v_r[0]),
    .opA_i(a_r), .opB_i(b_r), .opA_signed_i(sa_r), .opB_signed_i(sb_r),
    .kill_i(kill_r), .v_o(v_o_w[0]), .result_o(res_w[0]), .yumi_i(yumi_r[0]));

  bsg_mul_iterative_booth4 #(.width_p(W), .digits_per_iter_p(4)) dut_d4 (
    .clk_i(clk), .reset_n_i(rst_n), .ready_o(ready_w[1]), .v_i(v_r[1]),
    .opA_i(a_r), .opB_i(b_r), .opA_signed_i(sa_r), .opB_signed_i(sb_r),
    .kill_i(kill_r), .v_o(v_o_w[1]), .result_o(res_w[1]), .yumi_i(yumi_r[1]));

  bsg_mul_iterative_booth4 #(.width_p(W), .digits_per_iter_p(17)) dut_d17 (
    .clk_i(clk), .reset_n_i(rst_n), .ready_o(ready_w[2]), .v_i(v_r[2]),
    .opA_i(a_r), .opB_i(b_r), .opA_signed_i(sa_r), .opB_signed_i(sb_r),
    .kill_i(kill_r), .v_o(v_o_w[2]), .result_o(res_w[2]), .yumi_i(yumi_r[2]));

  function automatic int dpi_of(input int d);
    case (d)
      0:       return 1;
      1:       return 4;
      default: return 17;
    endcase
  endfunction

  // Latency from the accept cycle to the first v_o cycle.
  function automatic int latency_of(input int d);
    int digits;
    digits = (W + 2) / 2;
    return (digits + dpi_of(d) - 1) / dpi_of(d) + 2;
  endfunction

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sa, input logic sb);
    logic signed [2*W+1:0] ea, eb, p;
    ea = $signed({{(W + 2){sa & a[W-1]}}, a});
    eb = $signed({{(W + 2){sb & b[W-1]}}, b});
    p  = ea * eb;
    return p[2*W-1:0];
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sa, input logic sb);
    a_r  = a;
    b_r  = b;
    sa_r = sa;
    sb_r = sb;
    v_r  = '0;
    v_r[d] = 1'b1;
    tick();
    v_r = '0;
  endtask

  // Bounded wait for v_o; lat stays -1 if it never arrives.
  task automatic wait_done(input int d, output int lat);
    lat = -1;
    for (int n = 0; n <= 40; n++) begin
      if (v_o_w[d]) begin
        lat = n + 1;
        break;
      end
      tick();
    end
  endtask

  task automatic run_op(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sa, input logic sb);
    int lat;
    logic [2*W-1:0] exp;
    exp = ref_mul(a, b, sa, sb);
    issue(d, a, b, sa, sb);
    wait_done(d, lat);
    check("latency", lat, latency_of(d));
    check("result", res_w[d], exp);
    $display("op dpi=%0d a=%h sa=%0d b=%h sb=%0d result=%h expected=%h latency=%0d",
             dpi_of(d), a, sa, b, sb, res_w[d], exp, lat);
    if (lat >= 0) yumi_r[d] = 1'b1;
    else          kill_r = 1'b1;
    tick();
    yumi_r = '0;
    kill_r = 1'b0;
    check("v_o_after_yumi", v_o_w[d], 1'b0);
    check("ready_after_yumi", ready_w[d], 1'b1);
    check("result_retained", res_w[d], exp);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    logic saw_v;
    logic [W-1:0] corner [5];
    logic [W-1:0] a, b;

    corner[0] = 32'h0000_0000;
    corner[1] = 32'h0000_0001;
    corner[2] = 32'h7FFF_FFFF;
    corner[3] = 32'h8000_0000;
    corner[4] = 32'hFFFF_FFFF;

    rst_n = 1'b0; v_r = '0; yumi_r = '0; kill_r = 1'b0;
    a_r = '0; b_r = '0; sa_r = 1'b0; sb_r = 1'b0;
    #12;
    for (int d = 0; d < 3; d++) begin
      check("reset_ready", ready_w[d], 1'b1);
      check("reset_v_o", v_o_w[d], 1'b0);
      check("reset_result", res_w[d], '0);
    end
    rst_n = 1'b1;
    tick();

    // MUL / MULHU / MULHSU corners on the 4-digit configuration.
    run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
    check("neg1_sq_signed", res_w[1], 64'h0000_0000_0000_0001);
    run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("max_sq_unsigned", res_w[1], 64'hFFFF_FFFE_0000_0001);
    run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check("mulhsu", res_w[1], 64'hFFFF_FFFF_0000_0001);
    run_op(1, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
    check("min_sq_signed", res_w[1], 64'h4000_0000_0000_0000);

    // Result must hold while the consumer stalls.
    issue(1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);
    wait_done(1, lat);
    check("hold_latency", lat, latency_of(1));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_v_o", v_o_w[1], 1'b1);
      check("hold_result", res_w[1], 64'hC000_0000_8000_0000);
    end
    $display("op hold a=7fffffff b=80000000 result=%h", res_w[1]);
    yumi_r[1] = 1'b1;
    tick();
    yumi_r = '0;
    check("hold_released", v_o_w[1], 1'b0);

    // Kill in eCal abandons the op without ever raising v_o.
    issue(1, 32'd3, 32'd5, 1'b0, 1'b0);
    tick();
    kill_r = 1'b1;
    tick();
    kill_r = 1'b0;
    check("kill_ready", ready_w[1], 1'b1);
    check("kill_v_o", v_o_w[1], 1'b0);
    saw_v = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      saw_v = saw_v | v_o_w[1];
    end
    check("kill_no_result", saw_v, 1'b0);
    $display("op kill a=3 b=5 abandoned");
    run_op(1, 32'd6, 32'd7, 1'b0, 1'b0);
    check("after_kill_42", res_w[1], 64'd42);

    // Kill together with v_i while idle still accepts the op.
    a_r = 32'd9; b_r = 32'hFFFF_FFFD; sa_r = 1'b0; sb_r = 1'b1;
    v_r = 3'b010;
    kill_r = 1'b1;
    tick();
    v_r = '0;
    kill_r = 1'b0;
    check("kill_idle_accepted", ready_w[1], 1'b0);
    wait_done(1, lat);
    check("kill_idle_latency", lat, latency_of(1));
    check("kill_idle_result", res_w[1], 64'hFFFF_FFFF_FFFF_FFE5);
    $display("op kill+accept a=9 b=-3 result=%h", res_w[1]);
    yumi_r[1] = 1'b1;
    tick();
    yumi_r = '0;

    // Asynchronous reset in the middle of eCal.
    issue(1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    check("async_rst_v_o", v_o_w[1], 1'b0);
    check("async_rst_ready", ready_w[1], 1'b1);
    check("async_rst_result", res_w[1], '0);
    $display("op reset mid-calculation");
    #2;
    rst_n = 1'b1;
    tick();

    // Randomized operands across all three configurations.
    for (int i = 0; i < 1200; i++) begin
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      run_op(i % 3, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
